thread_scheduler: RTL and testbench

- Round-robin issue scheduler for the 4-thread barrel pipeline.
- Each cycle the pipeline advances, it picks the next eligible hardware thread and drives the register-file read thread ID (thread_rs_id).
- Tracks every issued instruction through a writeback-delay shift chain and drives the matching write thread ID (thread_rd_id) with its valid.
- Holds a thread ineligible while it has an instruction in flight, so no intra-thread RAW hazard reaches the register file.

---
 rtl/thread_scheduler.sv | 128 ++++++++++++
 tb/tb_thread_scheduler.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/thread_scheduler.sv
// thread_scheduler: round-robin issue scheduler for the 4-thread barrel pipeline.
// Picks the next eligible thread on every pipeline advance. Tracks each issued
// slot through a WB_LATENCY-deep stage chain and keeps a thread ineligible while
// any of its slots is in flight.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   pipe_adv       pipeline advance; when low, all state holds
//   thread_active  per-thread enable
//   thread_stall   per-thread stall, sampled in the current cycle
//   issue_valid    S1 holds a valid issued slot
//   thread_rs_id   thread ID in S1 (register-file read index)
//   wb_valid       S[WB_LATENCY] holds a valid slot
//   thread_rd_id   thread ID in S[WB_LATENCY] (register-file write index)
//   thread_busy    per-thread in-flight flag (combinational from stage registers)
//
// Optional feature, enabled by defining THREAD_SCHED_STATS_EN:
//   stat_sel       counter select
//   stat_count     issue count of thread stat_sel (combinational read)

module thread_scheduler #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned WB_LATENCY  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_adv,
  input  logic [NUM_THREADS-1:0] thread_active,
  input  logic [NUM_THREADS-1:0] thread_stall,
  output logic                   issue_valid,
  output logic [1:0]             thread_rs_id,
  output logic                   wb_valid,
  output logic [1:0]             thread_rd_id,
  output logic [NUM_THREADS-1:0] thread_busy
`ifdef THREAD_SCHED_STATS_EN
  ,
  input  logic [1:0]             stat_sel,
  output logic [31:0]            stat_count
`endif
);

  localparam int unsigned IdW  = 2;
  localparam int unsigned CntW = 32;

  typedef struct packed {
    logic           valid;
    logic [IdW-1:0] id;
  } stage_t;

  // Index 0 is S1 (issue), index WB_LATENCY-1 is the writeback stage.
  stage_t [WB_LATENCY-1:0] stage_q, stage_d;
  logic   [IdW-1:0]        last_ptr_q, last_ptr_d;

  logic [NUM_THREADS-1:0] elig;
  logic [IdW-1:0]         sel;
  logic                   any_elig;

  // In-flight flags: any valid stage carrying the thread's ID.
  always_comb begin
    thread_busy = '0;
    for (int unsigned k = 0; k < WB_LATENCY; k++) begin
      if (stage_q[k].valid) thread_busy[stage_q[k].id] = 1'b1;
    end
  end

  assign elig = thread_active & ~thread_stall & ~thread_busy;

  // Round-robin search starting one past the last issued thread; the final
  // candidate is last_ptr itself.
  always_comb begin
    logic [IdW-1:0] cand;
    sel      = '0;
    any_elig = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= NUM_THREADS; i++) begin
      cand = last_ptr_q + IdW'(i);
      if (!any_elig && elig[cand]) begin
        sel      = cand;
        any_elig = 1'b1;
      end
    end
  end

  // Next state: shift the stage chain and load S1 with the selection or a bubble.
  always_comb begin
    stage_d          = stage_q;
    last_ptr_d       = last_ptr_q;
    stage_d[0].valid = any_elig;
    stage_d[0].id    = any_elig ? sel : '0;
    for (int unsigned k = 1; k < WB_LATENCY; k++) begin
      stage_d[k] = stage_q[k-1];
    end
    if (any_elig) last_ptr_d = sel;
  end

  // State registers; everything freezes while the pipeline is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q    <= '0;
      last_ptr_q <= IdW'(NUM_THREADS - 1);
    end else if (pipe_adv) begin
      stage_q    <= stage_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  assign issue_valid  = stage_q[0].valid;
  assign thread_rs_id = stage_q[0].id;
  assign wb_valid     = stage_q[WB_LATENCY-1].valid;
  assign thread_rd_id = stage_q[WB_LATENCY-1].id;

`ifdef THREAD_SCHED_STATS_EN
  logic [CntW-1:0] cnt_q [NUM_THREADS];

  // Per-thread issue counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) cnt_q[t] <= '0;
    end else if (pipe_adv && any_elig) begin
      cnt_q[sel] <= cnt_q[sel] + CntW'(1);
    end
  end

  assign stat_count = cnt_q[stat_sel];
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// tb_thread_scheduler: directed self-checking bench for thread_scheduler
// (WB_LATENCY = 3). Expected values are hand-derived round-robin sequences.

module tb_thread_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pipe_adv = 1'b1;
  logic [3:0] thread_active = 4'h0;
  logic [3:0] thread_stall = 4'h0;
  logic       issue_valid;
  logic [1:0] thread_rs_id;
  logic       wb_valid;
  logic [1:0] thread_rd_id;
  logic [3:0] thread_busy;
`ifdef THREAD_SCHED_STATS_EN
  logic [1:0]  stat_sel = 2'd0;
  logic [31:0] stat_count;
`endif

  int total = 0;
  int bad   = 0;

  thread_scheduler #(.NUM_THREADS(4), .WB_LATENCY(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .pipe_adv      (pipe_adv),
    .thread_active (thread_active),
    .thread_stall  (thread_stall),
    .issue_valid   (issue_valid),
    .thread_rs_id  (thread_rs_id),
    .wb_valid      (wb_valid),
    .thread_rd_id  (thread_rd_id),
    .thread_busy   (thread_busy)
`ifdef THREAD_SCHED_STATS_EN
    ,
    .stat_sel      (stat_sel),
    .stat_count    (stat_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to one time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse taken mid-cycle, released on a falling edge.
  task automatic pulse_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_iv"},   32'(issue_valid),  32'd0);
    check_eq({tag, "_wb"},   32'(wb_valid),     32'd0);
    check_eq({tag, "_rs"},   32'(thread_rs_id), 32'd0);
    check_eq({tag, "_rd"},   32'(thread_rd_id), 32'd0);
    check_eq({tag, "_busy"}, 32'(thread_busy),  32'd0);
  endtask

  int rot_rs   [6] = '{0, 1, 2, 3, 0, 1};
  int rot_busy [6] = '{4'h1, 4'h3, 4'h7, 4'he, 4'hd, 4'hb};
  int t2_iv    [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
  int t2_busy  [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
  int st_iv    [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
  int st_rs    [8] = '{0, 2, 3, 0, 0, 2, 3, 0};

  initial begin
    // Reset held: all outputs at their reset values.
    thread_active = 4'hf;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Full rotation with no bubbles; writeback trails issue by two advances.
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq($sformatf("rot_iv%0d", i),   32'(issue_valid),  32'd1);
      check_eq($sformatf("rot_rs%0d", i),   32'(thread_rs_id), 32'(rot_rs[i]));
      check_eq($sformatf("rot_busy%0d", i), 32'(thread_busy),  32'(rot_busy[i]));
      if (i >= 2) begin
        check_eq($sformatf("rot_wb%0d", i), 32'(wb_valid),     32'd1);
        check_eq($sformatf("rot_rd%0d", i), 32'(thread_rd_id), 32'(rot_rs[i-2]));
      end else begin
        check_eq($sformatf("rot_wb%0d", i), 32'(wb_valid),     32'd0);
      end
    end

    // Freeze for five edges: stages hold 1,0,3.
    pipe_adv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("frz_rs%0d", i),   32'(thread_rs_id), 32'd1);
      check_eq($sformatf("frz_iv%0d", i),   32'(issue_valid),  32'd1);
      check_eq($sformatf("frz_rd%0d", i),   32'(thread_rd_id), 32'd3);
      check_eq($sformatf("frz_busy%0d", i), 32'(thread_busy),  32'hb);
    end
    pipe_adv = 1'b1;
    step(); check_eq("res_rs0", 32'(thread_rs_id), 32'd2); check_eq("res_rd0", 32'(thread_rd_id), 32'd0);
    step(); check_eq("res_rs1", 32'(thread_rs_id), 32'd3); check_eq("res_rd1", 32'(thread_rd_id), 32'd1);
    step(); check_eq("res_rs2", 32'(thread_rs_id), 32'd0); check_eq("res_rd2", 32'(thread_rd_id), 32'd2);

    // Asynchronous reset with three slots in flight.
    #2 rst = 1'b0;
    #1;
    check_all_zero("arst");
    @(negedge clk);
    rst = 1'b1;
    step();
    check_eq("post_iv0", 32'(issue_valid),  32'd1);
    check_eq("post_rs0", 32'(thread_rs_id), 32'd0);
    check_eq("post_wb0", 32'(wb_valid),     32'd0);
    step();
    check_eq("post_wb1", 32'(wb_valid),     32'd0);
    step();
    check_eq("post_wb2", 32'(wb_valid),     32'd1);
    check_eq("post_rd2", 32'(thread_rd_id), 32'd0);

    // Only thread 2 active: one issue every four advances.
    thread_active = 4'b0100;
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq($sformatf("t2_iv%0d", i),   32'(issue_valid),    32'(t2_iv[i]));
      check_eq($sformatf("t2_rs%0d", i),   32'(thread_rs_id),   t2_iv[i] != 0 ? 32'd2 : 32'd0);
      check_eq($sformatf("t2_busy%0d", i), 32'(thread_busy[2]), 32'(t2_busy[i]));
    end

    // Thread 1 stalled: 0,2,3,bubble; release restores 1 after 0.
    thread_active = 4'hf;
    thread_stall  = 4'b0010;
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq($sformatf("st_iv%0d", i), 32'(issue_valid),  32'(st_iv[i]));
      check_eq($sformatf("st_rs%0d", i), 32'(thread_rs_id), 32'(st_rs[i]));
    end
    thread_stall = 4'b0000;
    step(); check_eq("rel_rs0", 32'(thread_rs_id), 32'd0);
    step(); check_eq("rel_rs1", 32'(thread_rs_id), 32'd1);
    step(); check_eq("rel_rs2", 32'(thread_rs_id), 32'd2);

    // No thread eligible: bubble and pointer held, then resume at thread 3.
    thread_active = 4'h0;
    step(); check_eq("none_iv0", 32'(issue_valid), 32'd0);
    step(); check_eq("none_iv1", 32'(issue_valid), 32'd0);
    step(); check_eq("none_busy", 32'(thread_busy), 32'd0);
    thread_active = 4'hf;
    step(); check_eq("none_rs", 32'(thread_rs_id), 32'd3);

`ifdef THREAD_SCHED_STATS_EN
    pulse_reset();
    for (int i = 0; i < 40; i++) step();
    pipe_adv = 1'b0;
    for (int s = 0; s < 4; s++) begin
      stat_sel = 2'(s);
      #1;
      check_eq($sformatf("stat%0d", s), stat_count, 32'd10);
    end
    pipe_adv = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
